booth_mult_seq: RTL

Parametrised sequential radix-2 Booth multiplier. Successor to the fixed 4-bit Booth block: operand width is generic, signed or unsigned operation is selected per operation, and it has a start/busy/done handshake with a held result. It serves as the shared multiply unit for the lab datapaths and is driven by a controller FSM or a testbench.

---
 rtl/booth_mult_seq.sv | 95 +++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation, result held until next start.
// Latency WIDTH+2 cycles from accepted start to done; start is ignored while busy, with no queuing.
module booth_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int W1 = WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH);

    logic [1:0]    state;
    logic [5:0]    cnt;
    logic [W1-1:0] m;
    logic [W1-1:0] p_hi;
    logic [W1-1:0] q;
    logic          q_m1;

    logic [W1-1:0] a_ext;
    logic [W1-1:0] b_ext;
    logic [W1-1:0] sum;
    logic [W1-1:0] p_nxt;
    logic [W1-1:0] q_nxt;

    // One extra bit lets unsigned operands run through the same two's complement recoding.
    assign a_ext = {signed_mode & a[WIDTH-1], a};
    assign b_ext = {signed_mode & b[WIDTH-1], b};

    always_comb begin
        sum = p_hi;
        case ({q[0], q_m1})
            2'b01:   sum = p_hi + m;
            2'b10:   sum = p_hi - m;
            default: sum = p_hi;
        endcase
        p_nxt = {sum[W1-1], sum[W1-1:1]};
        q_nxt = {sum[0], q[W1-1:1]};
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            product <= '0;
            m       <= '0;
            p_hi    <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        m     <= a_ext;
                        p_hi  <= '0;
                        q     <= b_ext;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    p_hi <= p_nxt;
                    q    <= q_nxt;
                    q_m1 <= q[0];
                    cnt  <= cnt + 6'd1;
                    if (cnt == LAST_STEP) begin
                        state <= S_DONE;
                        // Top two bits of the 2*W1 result are pure sign copies and are dropped.
                        product <= {p_nxt[WIDTH-2:0], q_nxt};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
